// File: rtl/bus_mux_pipe.sv
// bus_mux_pipe: channel select + zero/sign extend into a 2-deep skid pipe.
// Ports: clk, rst (async high), in_data/in_sel/in_sext/in_valid/in_ready,
//        out_data/out_err/out_valid/out_ready.
module bus_mux_pipe #(
  parameter int NCH   = 2,
  parameter int IN_W  = 4,
  parameter int OUT_W = 16,
  localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH*IN_W-1:0] in_data,
  input  logic [SEL_W-1:0]    in_sel,
  input  logic                in_sext,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_err,
  output logic                out_valid,
  input  logic                out_ready
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t state, state_n;

  logic [IN_W-1:0]  chan;
  logic             hit;
  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] word;
  logic             word_err;

  logic [OUT_W-1:0] out_q, skid_q;
  logic             err_q, skid_err;

  logic in_xfer, out_xfer;
  logic ld_out, ld_skid, mv_skid;

  always_comb begin
    chan = '0;
    hit  = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (in_sel == SEL_W'(k)) begin
        chan = in_data[k*IN_W +: IN_W];
        hit  = 1'b1;
      end
    end
  end

  generate
    if (IN_W < OUT_W) begin : g_ext
      assign ext = {{(OUT_W-IN_W){in_sext & chan[IN_W-1]}}, chan};
    end else begin : g_trunc
      // Narrowing drops the upper channel bits; sign mode is moot.
      logic unused_ok;
      assign unused_ok = ^{in_sext, chan};
      assign ext = chan[OUT_W-1:0];
    end
  endgenerate

  assign word     = hit ? ext : '0;
  assign word_err = ~hit;

  // Ready depends on registered state only; reset holds it low.
  assign in_ready  = ~rst & (state != TWO);
  assign out_valid = (state != EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    ld_out  = 1'b0;
    ld_skid = 1'b0;
    mv_skid = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_xfer) begin
          ld_out  = 1'b1;
          state_n = ONE;
        end
      end
      ONE: begin
        unique case (1'b1)
          (in_xfer & out_xfer): ld_out = 1'b1;
          (in_xfer & ~out_xfer): begin
            ld_skid = 1'b1;
            state_n = TWO;
          end
          (~in_xfer & out_xfer): state_n = EMPTY;
          default: ;
        endcase
      end
      TWO: begin
        if (out_xfer) begin
          mv_skid = 1'b1;
          state_n = ONE;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= '0;
      err_q    <= 1'b0;
      skid_q   <= '0;
      skid_err <= 1'b0;
    end else begin
      if (ld_out) begin
        out_q <= word;
        err_q <= word_err;
      end else if (mv_skid) begin
        out_q <= skid_q;
        err_q <= skid_err;
      end
      if (ld_skid) begin
        skid_q   <= word;
        skid_err <= word_err;
      end
    end
  end

  assign out_data = out_q;
  assign out_err  = err_q;

endmodule

// File: tb/tb_bus_mux_pipe.sv
// tb_bus_mux_pipe: directed bench with a queue model of the pipe.
// Default instance is model-checked every cycle; NCH=3 instance covers range.
module tb_bus_mux_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  in_data;
  logic [0:0]  in_sel;
  logic        in_sext, in_valid, in_ready;
  logic [15:0] out_data;
  logic        out_err, out_valid, out_ready;

  logic [11:0] d3_data;
  logic [1:0]  d3_sel;
  logic        d3_sext, d3_valid, d3_in_ready;
  logic [15:0] d3_out;
  logic        d3_err, d3_ovalid, d3_oready;

  bus_mux_pipe dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_sext(in_sext),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  bus_mux_pipe #(.NCH(3)) dut3 (
    .clk(clk), .rst(rst),
    .in_data(d3_data), .in_sel(d3_sel), .in_sext(d3_sext),
    .in_valid(d3_valid), .in_ready(d3_in_ready),
    .out_data(d3_out), .out_err(d3_err),
    .out_valid(d3_ovalid), .out_ready(d3_oready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected {err, data} for a 2-channel, 4-bit input, 16-bit output word.
  function automatic logic [16:0] mdl(logic [7:0] d, int sel, logic sx);
    logic [15:0] v;
    if (sel >= 2) return 17'h10000;
    v = 16'((d >> (sel * 4)) & 8'h0F);
    if (sx && v >= 16'd8) v = v + 16'hFFF0;
    return {1'b0, v};
  endfunction

  // Model: an in-order FIFO holding at most two words.
  logic [16:0] q[$];
  always @(posedge clk or posedge rst) begin
    if (rst) q.delete();
    else begin : upd
      bit acc, dlv;
      acc = in_valid && (q.size() < 2);
      dlv = out_ready && (q.size() > 0);
      if (dlv) void'(q.pop_front());
      if (acc) q.push_back(mdl(in_data, int'(in_sel), in_sext));
    end
  end

  always @(negedge clk) begin
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, (q.size() < 2) && !rst);
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0][15:0]);
      chk("out_err", out_err, q[0][16]);
    end
  end

  logic [16:0] got[$];
  int got_cyc[$];
  int cyc_n = 0;
  always @(negedge clk) begin
    cyc_n++;
    if (!rst && out_valid && out_ready) begin
      got.push_back({out_err, out_data});
      got_cyc.push_back(cyc_n);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(logic [7:0] d, logic s, logic sx);
    logic r;
    logic ok;
    ok = 1'b0;
    in_data  = d;
    in_sel   = s;
    in_sext  = sx;
    in_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      r = in_ready;
      cyc();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    chk("offer_accepted", ok, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    in_data = '0; in_sel = '0; in_sext = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    d3_data = '0; d3_sel = '0; d3_sext = 1'b0;
    d3_valid = 1'b0; d3_oready = 1'b1;
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_d3_valid", d3_ovalid, 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("ready_after_rst", in_ready, 1);

    // Extension modes
    out_ready = 1'b1;
    offer(8'hA3, 1'b0, 1'b0);
    chk("zext_data", out_data, 16'h0003);
    chk("zext_valid", out_valid, 1);
    chk("zext_err", out_err, 0);
    offer(8'hA3, 1'b1, 1'b1);
    chk("sext_data", out_data, 16'hFFFA);
    offer(8'hA3, 1'b1, 1'b0);
    chk("zext_ch1", out_data, 16'h000A);
    cyc();
    chk("drained", out_valid, 0);

    // Backpressure
    out_ready = 1'b0;
    got.delete();
    offer(8'h35, 1'b0, 1'b0);
    offer(8'h35, 1'b1, 1'b0);
    chk("bp_ready_low", in_ready, 0);
    in_data = 8'h7C; in_sel = 1'b0; in_sext = 1'b1; in_valid = 1'b1;
    repeat (3) cyc();
    chk("bp_hold_data", out_data, 16'h0005);
    chk("bp_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    offer(8'h7C, 1'b0, 1'b1);
    repeat (3) cyc();
    chk("bp_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("bp_w0", got[0], 17'h00005);
      chk("bp_w1", got[1], 17'h00003);
      chk("bp_w2", got[2], 17'h0FFFC);
    end

    // Throughput
    got.delete();
    got_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      logic [3:0] iv;
      iv = 4'(i);
      chk("tp_ready", in_ready, 1);
      offer({iv, ~iv}, iv[0], 1'b0);
    end
    repeat (2) cyc();
    chk("tp_count", got.size(), 8);
    if (got.size() == 8) begin
      chk("tp_span", got_cyc[7] - got_cyc[0], 7);
      chk("tp_first", got[0], 17'h0000F);
      chk("tp_last", got[7], 17'h00007);
    end

    // Out-of-range select on the 3-channel instance
    d3_data = 12'hFFF; d3_sel = 2'd3; d3_sext = 1'b1; d3_valid = 1'b1;
    cyc();
    chk("oor_data", d3_out, 16'h0000);
    chk("oor_err", d3_err, 1);
    chk("oor_valid", d3_ovalid, 1);
    d3_data = 12'h5FF; d3_sel = 2'd2; d3_sext = 1'b0;
    cyc();
    chk("ch2_data", d3_out, 16'h0005);
    chk("ch2_err", d3_err, 0);
    d3_data = 12'h9AB; d3_sext = 1'b1;
    cyc();
    chk("ch2_sext", d3_out, 16'hFFF9);
    d3_valid = 1'b0;
    cyc();
    chk("d3_drained", d3_ovalid, 0);

    // Asynchronous reset while full
    out_ready = 1'b0;
    offer(8'h12, 1'b0, 1'b0);
    offer(8'h34, 1'b1, 1'b0);
    chk("full_ready", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_err", out_err, 0);
    chk("arst_ready", in_ready, 0);
    cyc();
    rst = 1'b0;
    got.delete();
    #1;
    chk("arst_release_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (3) cyc();
    chk("arst_no_stale", got.size(), 0);
    chk("arst_idle", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_mux_pipe.md
BUS_MUX_PIPE -- requirements
Module: bus_mux_pipe

Interface
REQ-001 SHALL have parameter NCH, default 2, number of input channels (2..16).
REQ-002 SHALL have parameter IN_W, default 4, width of each input channel.
REQ-003 SHALL have parameter OUT_W, default 16, width of output word.
REQ-004 SHALL have derived localparam SEL_W = max(1, clog2(NCH)).
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port in_data, input, NCH*IN_W, flattened channels; channel k occupies bits [k*IN_W +: IN_W].
REQ-008 SHALL have port in_sel, input, SEL_W, channel index.
REQ-009 SHALL have port in_sext, input, 1, 1 = sign-extend, 0 = zero-extend.
REQ-010 SHALL have port in_valid, input, 1, upstream word offered.
REQ-011 SHALL have port in_ready, output, 1, block can accept a word.
REQ-012 SHALL have port out_data, output, OUT_W, selected and extended word.
REQ-013 SHALL have port out_err, output, 1, word was produced from an out-of-range in_sel.
REQ-014 SHALL have port out_valid, output, 1, out_data/out_err valid.
REQ-015 SHALL have port out_ready, input, 1, downstream accepts.

Function
REQ-016 Input transfer SHALL occur on a rising edge where in_valid && in_ready; output transfer SHALL occur where out_valid && out_ready.
REQ-017 On input transfer, the captured word SHALL be in_data channel in_sel, sampled in that cycle.
REQ-018 If IN_W < OUT_W, bits [OUT_W-1:IN_W] SHALL be zero when in_sext=0, and copies of channel bit IN_W-1 when in_sext=1.
REQ-019 If IN_W >= OUT_W, the word SHALL be the low OUT_W bits of the channel, with in_sext ignored.
REQ-020 If in_sel >= NCH, the captured data SHALL be all zeros with err=1; otherwise err=0.
REQ-021 Storage SHALL be an output register plus one skid register; FSM states EMPTY, ONE, TWO.
REQ-022 EMPTY: in_ready=1, out_valid=0; an input transfer SHALL load the output register and go to ONE.
REQ-023 ONE, input transfer only: the word SHALL go to the skid register; state SHALL go to TWO.
REQ-024 ONE, output transfer only: state SHALL go to EMPTY.
REQ-025 ONE, simultaneous input and output transfer: the output register SHALL load the new word; state SHALL stay ONE.
REQ-026 TWO: in_ready=0.
REQ-027 TWO, on output transfer: the skid word SHALL move to the output register; state SHALL go to ONE.
REQ-028 in_ready SHALL be driven only from registered state (no combinational path from out_ready).
REQ-029 out_data/out_err SHALL be driven directly from the output register.
REQ-030 Latency SHALL be 1 cycle: a word accepted at edge N is visible with out_valid=1 after edge N when state was EMPTY.
REQ-031 Words SHALL emerge in acceptance order, with none dropped or duplicated.
REQ-032 out_data and out_err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-033 in_valid with in_ready=0 SHALL have no effect.
REQ-034 Sustained in_valid=out_ready=1 SHALL give one word per cycle.

Reset
REQ-035 rst=1 SHALL immediately, without a clock, force state EMPTY, out_valid=0, out_data=0, out_err=0, skid register=0.
REQ-036 While rst=1, in_ready SHALL be 0; after release, in_ready SHALL be 1.
REQ-037 Reset asserted mid-stream SHALL discard all held words; no stale word SHALL appear after release.

Verification
REQ-038 Zero-extend: defaults, in_data={ch1=4'hA, ch0=4'h3}, in_sel=0, in_sext=0, one transfer -> next cycle out_data=16'h0003, out_valid=1, out_err=0.
REQ-039 Sign-extend: in_sel=1 (ch1=4'hA), in_sext=1 -> out_data=16'hFFFA; same with in_sext=0 -> 16'h000A.
REQ-040 Backpressure: out_ready=0, three words offered back-to-back -> first two accepted (in_ready drops after 2nd), third held; out_ready=1 -> all three emerge in order, none lost.
REQ-041 Throughput: out_ready=1, in_valid=1 for 8 cycles with distinct words -> 8 outputs on consecutive cycles, in_ready stays 1.
REQ-042 Out-of-range: NCH=3, in_sel=3 -> out_data=0, out_err=1; next word with in_sel=2 -> out_err=0.
REQ-043 Async reset: state TWO, assert rst between edges -> out_valid=0 and out_data=0 before next edge; after release in_ready=1, no old word output.
